// File: rtl/servo_frame_decoder_if.sv
// Byte stream from the UART receiver into the servo frame decoder.
// The receiver drives the master side; the decoder listens on the slave side.
interface servo_frame_decoder_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_error;

    modport master (output rx_data, output rx_valid, output rx_error);
    modport slave  (input  rx_data, input  rx_valid, input  rx_error);
endinterface

// File: rtl/servo_frame_decoder.sv
// Parses SYNC/X/Y/CHK frames from the UART byte stream into registered X/Y servo
// positions, with a link watchdog that re-centres both axes when frames stop.
module servo_frame_decoder #(
    parameter logic [6:0]  CENTER_POS     = 7'd64,
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hFF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    servo_frame_decoder_if.slave   rx,
    output logic [6:0]             pos_x,
    output logic [6:0]             pos_y,
    output logic                   frame_valid,
    output logic                   link_timeout,
    output logic [7:0]             error_count
);

    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, GET_X, GET_Y, GET_CHK} state_t;

    state_t            state_reg, state_next;
    logic [6:0]        x_tmp_reg, x_tmp_next;
    logic [6:0]        y_tmp_reg, y_tmp_next;
    logic [6:0]        pos_x_reg, pos_y_reg;
    logic              frame_valid_reg, link_timeout_reg;
    logic [7:0]        error_count_reg;
    logic [WD_W-1:0]   wd_cnt_reg;
    logic              err_hit, accept, wd_expire;

    assign wd_expire = (wd_cnt_reg == WD_LAST);

    always_comb begin
        state_next = state_reg;
        x_tmp_next = x_tmp_reg;
        y_tmp_next = y_tmp_reg;
        err_hit    = 1'b0;
        accept     = 1'b0;
        // A UART error discards the byte and abandons any frame in progress.
        if (rx.rx_error) begin
            if (state_reg != IDLE) begin
                err_hit    = 1'b1;
                state_next = IDLE;
            end
        end else if (rx.rx_valid) begin
            case (state_reg)
                IDLE: begin
                    if (rx.rx_data == SYNC_BYTE) state_next = GET_X;
                end
                GET_X: begin
                    if (!rx.rx_data[7]) begin
                        x_tmp_next = rx.rx_data[6:0];
                        state_next = GET_Y;
                    end else begin
                        err_hit    = 1'b1;
                        state_next = (rx.rx_data == SYNC_BYTE) ? GET_X : IDLE;
                    end
                end
                GET_Y: begin
                    if (!rx.rx_data[7]) begin
                        y_tmp_next = rx.rx_data[6:0];
                        state_next = GET_CHK;
                    end else begin
                        err_hit    = 1'b1;
                        state_next = (rx.rx_data == SYNC_BYTE) ? GET_X : IDLE;
                    end
                end
                GET_CHK: begin
                    if (rx.rx_data == {1'b0, x_tmp_reg ^ y_tmp_reg}) begin
                        accept     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        err_hit    = 1'b1;
                        state_next = (rx.rx_data == SYNC_BYTE) ? GET_X : IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            x_tmp_reg <= '0;
            y_tmp_reg <= '0;
        end else begin
            state_reg <= state_next;
            x_tmp_reg <= x_tmp_next;
            y_tmp_reg <= y_tmp_next;
        end
    end

    // An accepted frame outranks a watchdog expiry landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_x_reg        <= CENTER_POS;
            pos_y_reg        <= CENTER_POS;
            frame_valid_reg  <= 1'b0;
            link_timeout_reg <= 1'b1;
            wd_cnt_reg       <= '0;
        end else begin
            frame_valid_reg <= accept;
            if (accept) begin
                pos_x_reg        <= x_tmp_reg;
                pos_y_reg        <= y_tmp_reg;
                link_timeout_reg <= 1'b0;
                wd_cnt_reg       <= '0;
            end else if (wd_expire) begin
                pos_x_reg        <= CENTER_POS;
                pos_y_reg        <= CENTER_POS;
                link_timeout_reg <= 1'b1;
            end else begin
                wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_count_reg <= 8'd0;
        end else if (err_hit && (error_count_reg != 8'hFF)) begin
            error_count_reg <= error_count_reg + 8'd1;
        end
    end

    assign pos_x        = pos_x_reg;
    assign pos_y        = pos_y_reg;
    assign frame_valid  = frame_valid_reg;
    assign link_timeout = link_timeout_reg;
    assign error_count  = error_count_reg;

endmodule

// File: tb/tb_servo_frame_decoder.sv
// Directed bench for servo_frame_decoder: frames, errors, watchdog, saturation, async reset.
module tb_servo_frame_decoder;

    logic       clk;
    logic       rst_n;
    logic [6:0] pos_x, pos_y;
    logic       frame_valid, link_timeout;
    logic [7:0] error_count;
    int         checks;
    int         errors;

    servo_frame_decoder_if rx_if ();

    servo_frame_decoder #(
        .CENTER_POS     (7'd64),
        .TIMEOUT_CYCLES (100),
        .SYNC_BYTE      (8'hFF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx           (rx_if.slave),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .frame_valid  (frame_valid),
        .link_timeout (link_timeout),
        .error_count  (error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Byte is presented for one full cycle starting at a falling edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_if.rx_data  = b;
        rx_if.rx_valid = 1'b1;
        @(negedge clk);
        rx_if.rx_valid = 1'b0;
    endtask

    task automatic send_err();
        @(negedge clk);
        rx_if.rx_error = 1'b1;
        @(negedge clk);
        rx_if.rx_error = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] s, input logic [7:0] x,
                              input logic [7:0] y, input logic [7:0] c);
        send_byte(s);
        send_byte(x);
        send_byte(y);
        send_byte(c);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        rx_if.rx_data  = 8'h00;
        rx_if.rx_valid = 1'b0;
        rx_if.rx_error = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        check("reset_pos_x", {1'b0, pos_x}, 8'h40);
        check("reset_pos_y", {1'b0, pos_y}, 8'h40);
        check("reset_timeout", {7'd0, link_timeout}, 8'h01);
        check("reset_fv", {7'd0, frame_valid}, 8'h00);
        check("reset_errcnt", error_count, 8'h00);

        // 0x10 ^ 0x20 = 0x30
        send_frame(8'hFF, 8'h10, 8'h20, 8'h30);
        check("f1_fv", {7'd0, frame_valid}, 8'h01);
        check("f1_pos_x", {1'b0, pos_x}, 8'h10);
        check("f1_pos_y", {1'b0, pos_y}, 8'h20);
        check("f1_timeout", {7'd0, link_timeout}, 8'h00);
        check("f1_errcnt", error_count, 8'h00);
        @(negedge clk);
        check("f1_fv_single", {7'd0, frame_valid}, 8'h00);

        send_frame(8'hFF, 8'h10, 8'h20, 8'h31);
        check("badchk_fv", {7'd0, frame_valid}, 8'h00);
        check("badchk_pos_x", {1'b0, pos_x}, 8'h10);
        check("badchk_pos_y", {1'b0, pos_y}, 8'h20);
        check("badchk_errcnt", error_count, 8'h01);

        send_frame(8'hFF, 8'h7F, 8'h00, 8'h7F);
        check("edge_pos_x", {1'b0, pos_x}, 8'h7F);
        check("edge_pos_y", {1'b0, pos_y}, 8'h00);

        // Second FF restarts the frame; 0x01 ^ 0x02 = 0x03
        send_byte(8'hFF);
        send_byte(8'h05);
        send_frame(8'hFF, 8'h01, 8'h02, 8'h03);
        check("resync_fv", {7'd0, frame_valid}, 8'h01);
        check("resync_pos_x", {1'b0, pos_x}, 8'h01);
        check("resync_pos_y", {1'b0, pos_y}, 8'h02);
        check("resync_errcnt", error_count, 8'h02);

        // 0x80 as X returns to IDLE, so the following 10 20 30 is ignored.
        send_byte(8'hFF);
        send_byte(8'h80);
        check("badx_errcnt", error_count, 8'h03);
        send_byte(8'h10);
        send_byte(8'h20);
        send_byte(8'h30);
        check("badx_idle_pos_x", {1'b0, pos_x}, 8'h01);
        check("badx_idle_errcnt", error_count, 8'h03);

        send_byte(8'hFF);
        send_byte(8'h11);
        send_err();
        check("rxerr_errcnt", error_count, 8'h04);
        check("rxerr_pos_y", {1'b0, pos_y}, 8'h02);
        send_err();
        check("rxerr_idle_errcnt", error_count, 8'h04);

        // Watchdog: expiry lands 100 edges after the accepting edge.
        send_frame(8'hFF, 8'h20, 8'h40, 8'h60);
        check("wd_frame_pos_x", {1'b0, pos_x}, 8'h20);
        repeat (99) @(negedge clk);
        check("wd_before_pos_x", {1'b0, pos_x}, 8'h20);
        check("wd_before_timeout", {7'd0, link_timeout}, 8'h00);
        @(negedge clk);
        check("wd_after_pos_x", {1'b0, pos_x}, 8'h40);
        check("wd_after_pos_y", {1'b0, pos_y}, 8'h40);
        check("wd_after_timeout", {7'd0, link_timeout}, 8'h01);
        repeat (20) @(negedge clk);
        check("wd_hold_timeout", {7'd0, link_timeout}, 8'h01);

        send_frame(8'hFF, 8'h01, 8'h01, 8'h00);
        check("wd_recover_timeout", {7'd0, link_timeout}, 8'h00);
        check("wd_recover_pos_x", {1'b0, pos_x}, 8'h01);

        // CHK strobe sampled on edge 100 after acceptance: same edge as expiry.
        repeat (92) @(negedge clk);
        send_frame(8'hFF, 8'h33, 8'h0C, 8'h3F);
        check("coinc_fv", {7'd0, frame_valid}, 8'h01);
        check("coinc_pos_x", {1'b0, pos_x}, 8'h33);
        check("coinc_pos_y", {1'b0, pos_y}, 8'h0C);
        check("coinc_timeout", {7'd0, link_timeout}, 8'h00);
        @(negedge clk);
        check("coinc_timeout_next", {7'd0, link_timeout}, 8'h00);
        check("coinc_pos_x_next", {1'b0, pos_x}, 8'h33);

        for (int i = 0; i < 300; i++) begin
            send_frame(8'hFF, 8'h10, 8'h20, 8'h31);
        end
        check("sat_errcnt", error_count, 8'hFF);

        send_frame(8'hFF, 8'h10, 8'h20, 8'h30);
        check("pre_rst_pos_x", {1'b0, pos_x}, 8'h10);
        send_byte(8'hFF);
        send_byte(8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pos_x", {1'b0, pos_x}, 8'h40);
        check("arst_pos_y", {1'b0, pos_y}, 8'h40);
        check("arst_timeout", {7'd0, link_timeout}, 8'h01);
        check("arst_errcnt", error_count, 8'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Without a leading SYNC these bytes must not form a frame.
        send_byte(8'h20);
        send_byte(8'h30);
        send_byte(8'h10);
        check("nosync_fv", {7'd0, frame_valid}, 8'h00);
        check("nosync_pos_x", {1'b0, pos_x}, 8'h40);
        check("nosync_pos_y", {1'b0, pos_y}, 8'h40);
        check("nosync_errcnt", error_count, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/servo_frame_decoder.md
Name: servo_frame_decoder

Overview:
Sits directly upstream of the servo PWM drivers in the UART servo controller. It consumes the byte stream from the UART receiver and parses fixed 4-byte command frames carrying X and Y plate positions. It validates each frame and drives registered 7-bit positions to the X and Y PWM driver instances. A link watchdog returns both axes to centre if valid frames stop arriving.

Parameters:
CENTER_POS, 64, 7-bit position driven at reset and on watchdog timeout
TIMEOUT_CYCLES, 5000000, clk cycles without a valid frame before timeout (100 ms at 50 MHz); must be >= 2
SYNC_BYTE, 8'hFF, frame start marker

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  received byte from UART receiver
rx_valid  input  1  one-cycle strobe; rx_data is valid this cycle
rx_error  input  1  one-cycle strobe; UART framing/parity error on the current byte
pos_x  output  7  X-axis position to X PWM driver
pos_y  output  7  Y-axis position to Y PWM driver
frame_valid  output  1  one-cycle pulse when pos_x/pos_y are updated from a frame
link_timeout  output  1  high while the watchdog has expired
error_count  output  8  saturating count of rejected frames/bytes

Behaviour:
- Frame format: SYNC_BYTE, X, Y, CHK. X and Y are in 0x00..0x7F. CHK = X xor Y (7-bit, MSB 0).
- Reset (async assert, sync release): state IDLE; pos_x = pos_y = CENTER_POS; frame_valid = 0; link_timeout = 1; error_count = 0; watchdog counter = 0.
- States: IDLE, GET_X, GET_Y, GET_CHK. Transitions occur only on cycles with rx_valid = 1 or rx_error = 1.
- IDLE: SYNC_BYTE -> GET_X. Any other byte is discarded, with no error counted.
- GET_X / GET_Y: a byte <= 0x7F is latched into x_tmp / y_tmp and the FSM advances. SYNC_BYTE is treated as a resync: count one error, go to GET_X. Any other byte >= 0x80: count one error, go to IDLE.
- GET_CHK: if the byte equals {1'b0, x_tmp ^ y_tmp}, the frame is accepted and the FSM goes to IDLE. SYNC_BYTE: count one error, go to GET_X. Any other mismatch: count one error, go to IDLE.
- Accepted frame: on the clock edge after the CHK byte's rx_valid cycle, pos_x <= x_tmp, pos_y <= y_tmp, and both update together. In that same cycle frame_valid = 1 for exactly one cycle, link_timeout = 0, and the watchdog counter clears to 0. Latency is 1 cycle from the CHK strobe.
- rx_error takes priority over rx_valid in the same cycle. The byte is ignored. From a non-IDLE state: count one error, go to IDLE. In IDLE: no error is counted.
- error_count saturates at 255 and never wraps. It is cleared only by reset.
- Watchdog:
  - The counter increments every cycle and is cleared by an accepted frame.
  - When the counter reaches TIMEOUT_CYCLES-1, on the next edge pos_x and pos_y are forced to CENTER_POS and link_timeout is set to 1.
  - The counter then holds (saturates), and link_timeout stays 1 until the next accepted frame.
  - If a frame acceptance and timeout expiry coincide, the accepted frame wins: positions take the frame values, link_timeout = 0, counter = 0.
- pos_x and pos_y change only on an accepted frame, on timeout, or on reset. They never show partial-frame values.
- Asserting rst_n mid-frame aborts the frame immediately and restores all reset values.
- Output positions are 0..127, suited to the downstream driver's pulse-width mapping. There is no clamping.

Test Plan:
- Reset then idle: after reset, pos_x = pos_y = 64 and link_timeout = 1. Send FF 10 20 30 -> one cycle after the 0x30 strobe, pos_x = 0x10, pos_y = 0x20, frame_valid pulses once, link_timeout = 0, error_count = 0.
- Bad checksum: send FF 10 20 31 -> positions unchanged, frame_valid stays 0, error_count = 1. Then send FF 7F 00 7F -> pos_x = 0x7F, pos_y = 0x00.
- Resync: send FF 05 FF 01 02 03 -> error_count increments by 1; the frame 01/02/03 is accepted, so pos_x = 0x01, pos_y = 0x02.
- Invalid data and rx_error: send FF 80 -> error_count +1, FSM in IDLE. Send FF 11 with an rx_error strobe on the next byte -> error_count +1, positions unchanged. Send a lone rx_error in IDLE -> no count.
- Watchdog (TIMEOUT_CYCLES = 100): accept a frame with X = 0x20, Y = 0x40, then send no bytes -> 100 cycles after frame_valid, pos_x = pos_y = 64 and link_timeout = 1. A new valid frame clears link_timeout. Also make acceptance coincide with the expiry cycle -> the frame values win.
- Saturation and async reset: inject 300 bad frames -> error_count = 255. Drop rst_n mid-frame (after FF 10) -> outputs reset immediately without waiting for clk. After release, send 20 30 10 -> no update, because a frame requires SYNC_BYTE first.
